// File: rtl/cardio_svm_pkg.sv
// Shared constants, coefficient ROM and vote helper for the sequential
// 3-class one-vs-one cardio SVM controller.
package cardio_svm_pkg;

    localparam int N_FEAT = 21;
    localparam int FEAT_W = 4;
    localparam int W_W    = 8;
    localparam int ACC_W  = 13;
    localparam int N_CLF  = 3;
    localparam int IN_W   = N_FEAT * FEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_VOTE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    typedef logic signed [W_W-1:0]   weight_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic [1:0] cls;
        logic [5:0] votes;
    } vote_t;

    // Row c holds the weights of pairwise classifier c (0v1, 0v2, 1v2).
    localparam weight_t W [N_CLF][N_FEAT] = '{
        '{-8'sd12,  8'sd68, -8'sd28,  8'sd42,  8'sd8,   8'sd0,  -8'sd36,
          -8'sd40,  8'sd9,  -8'sd20, -8'sd8,  -8'sd3,  -8'sd16, -8'sd20,
          -8'sd17,  8'sd12, -8'sd13, -8'sd28, -8'sd11, -8'sd28, -8'sd3},
        '{-8'sd29,  8'sd21, -8'sd10,  8'sd34, -8'sd2,  -8'sd3,  -8'sd52,
          -8'sd46, -8'sd6,  -8'sd33,  8'sd1,  -8'sd4,  -8'sd2,  -8'sd9,
           8'sd10, -8'sd3,   8'sd25,  8'sd28,  8'sd34, -8'sd40, -8'sd6},
        '{ 8'sd1,   8'sd10, -8'sd13, -8'sd4,  -8'sd14, -8'sd15, -8'sd31,
          -8'sd23, -8'sd8,  -8'sd30,  8'sd10, -8'sd1,   8'sd5,   8'sd3,
           8'sd24, -8'sd8,   8'sd20,  8'sd37,  8'sd25, -8'sd18, -8'sd1}
    };

    localparam acc_t INTERCEPT [N_CLF] = '{13'sd1374, 13'sd346, -13'sd231};

    function automatic weight_t weight_at(input logic [1:0] c, input logic [4:0] f);
        weight_t w;
        if ((c < 2'd3) && (f < 5'd21)) begin
            w = W[c][f];
        end else begin
            w = 8'sd0;
        end
        return w;
    endfunction

    // Index 3 is reached when the last classifier finishes; nothing uses it.
    function automatic acc_t intercept_at(input logic [1:0] c);
        acc_t v;
        case (c)
            2'd0:    v = INTERCEPT[0];
            2'd1:    v = INTERCEPT[1];
            2'd2:    v = INTERCEPT[2];
            default: v = 13'sd0;
        endcase
        return v;
    endfunction

    function automatic vote_t vote_argmax(input logic [2:0] d);
        vote_t      r;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] best;
        logic [1:0] best_sum;
        s0 = {1'b0, ~d[0]} + {1'b0, ~d[1]};
        s1 = {1'b0,  d[0]} + {1'b0, ~d[2]};
        s2 = {1'b0,  d[1]} + {1'b0,  d[2]};
        if (s0 >= s1) begin
            best     = 2'd0;
            best_sum = s0;
        end else begin
            best     = 2'd1;
            best_sum = s1;
        end
        if (best_sum >= s2) begin
            r.cls = best;
        end else begin
            r.cls = 2'd2;
        end
        r.votes = {s0, s1, s2};
        return r;
    endfunction

endpackage

// File: rtl/cardio_svm_seq_ctrl_if.sv
// Sample-in / result-out valid-ready bundle of the sequential SVM controller.
interface cardio_svm_seq_ctrl_if;
    import cardio_svm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_class;
    logic [5:0]      out_votes;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class, out_votes
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class, out_votes
    );

endinterface

// File: rtl/svm_mac_unit.sv
// Single unsigned 4-bit x signed 8-bit multiplier feeding a 13-bit wrapping
// accumulator; load takes priority over accumulate.
module svm_mac_unit
    import cardio_svm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              acc_en_i,
    input  acc_t              load_val_i,
    input  logic [FEAT_W-1:0] feat_i,
    input  weight_t           w_i,
    output acc_t              sum_o
);

    acc_t               acc_q;
    acc_t               acc_d;
    logic signed [11:0] feat_x_s;
    logic signed [11:0] w_x_s;
    logic signed [11:0] prod_s;

    // Product fits in 12 bits (15 * -128 = -1920); the add wraps at 13 bits.
    always_comb begin
        feat_x_s = {7'd0, feat_i};
        w_x_s    = {{4{w_i[W_W-1]}}, w_i};
        prod_s   = feat_x_s * w_x_s;
        sum_o    = acc_q + {prod_s[11], prod_s};
        if (load_i) begin
            acc_d = load_val_i;
        end else if (acc_en_i) begin
            acc_d = sum_o;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 13'sd0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cardio_svm_seq_ctrl.sv
// Sequential one-vs-one SVM controller: 63 MAC cycles over three pairwise
// classifiers, one vote cycle, then the result is held until consumed.
module cardio_svm_seq_ctrl
    import cardio_svm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cardio_svm_seq_ctrl_if.slave bus,
    output logic                 busy
);

    state_e          state_q;
    state_e          state_d;
    logic [1:0]      c_q;
    logic [1:0]      c_d;
    logic [4:0]      f_q;
    logic [4:0]      f_d;
    logic [2:0]      dec_q;
    logic [2:0]      dec_d;
    logic [IN_W-1:0] feat_q;
    logic [IN_W-1:0] feat_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic [1:0]      out_class_q;
    logic [1:0]      out_class_d;
    logic [5:0]      out_votes_q;
    logic [5:0]      out_votes_d;

    logic              mac_load_s;
    logic              mac_acc_en_s;
    acc_t              mac_load_val_s;
    acc_t              mac_sum_s;
    logic [FEAT_W-1:0] feat_sel_s;
    weight_t           weight_sel_s;
    vote_t             vote_s;

    assign feat_sel_s   = feat_q[{f_q, 2'b00} +: FEAT_W];
    assign weight_sel_s = weight_at(c_q, f_q);
    assign vote_s       = vote_argmax(dec_q);

    svm_mac_unit u_mac (
        .clk        (clk),
        .rst        (rst),
        .load_i     (mac_load_s),
        .acc_en_i   (mac_acc_en_s),
        .load_val_i (mac_load_val_s),
        .feat_i     (feat_sel_s),
        .w_i        (weight_sel_s),
        .sum_o      (mac_sum_s)
    );

    // Next-state, counter, decision-bit and output-register logic.
    always_comb begin
        state_d        = state_q;
        c_d            = c_q;
        f_d            = f_q;
        dec_d          = dec_q;
        feat_d         = feat_q;
        out_valid_d    = out_valid_q;
        out_class_d    = out_class_q;
        out_votes_d    = out_votes_q;
        mac_load_s     = 1'b0;
        mac_acc_en_s   = 1'b0;
        mac_load_val_s = intercept_at(2'd0);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    feat_d     = bus.in_data;
                    mac_load_s = 1'b1;
                    c_d        = 2'd0;
                    f_d        = 5'd0;
                    dec_d      = 3'b000;
                    state_d    = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                mac_acc_en_s = 1'b1;
                if (f_q == 5'd20) begin
                    case (c_q)
                        2'd0:    dec_d[0] = mac_sum_s[ACC_W-1];
                        2'd1:    dec_d[1] = mac_sum_s[ACC_W-1];
                        2'd2:    dec_d[2] = mac_sum_s[ACC_W-1];
                        default: dec_d    = dec_q;
                    endcase
                    // Seed the next classifier in the same cycle its predecessor closes.
                    f_d            = 5'd0;
                    mac_load_s     = 1'b1;
                    mac_load_val_s = intercept_at(c_q + 2'd1);
                    if (c_q == 2'd2) begin
                        state_d = ST_VOTE;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end else begin
                    f_d = f_q + 5'd1;
                end
            end
            ST_VOTE: begin
                out_class_d = vote_s.cls;
                out_votes_d = vote_s.votes;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            c_q         <= 2'd0;
            f_q         <= 5'd0;
            dec_q       <= 3'b000;
            feat_q      <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= 2'd0;
            out_votes_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            f_q         <= f_d;
            dec_q       <= dec_d;
            feat_q      <= feat_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_votes_q <= out_votes_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_votes = out_votes_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cardio_svm_seq_ctrl.sv
// Scoreboard bench for cardio_svm_seq_ctrl: directed vectors plus random
// samples checked against an independent parallel reference classifier.
module tb_cardio_svm_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    cardio_svm_seq_ctrl_if bus_if ();

    cardio_svm_seq_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cls;
        logic [5:0] votes;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam int RW [3][21] = '{
        '{-12, 68, -28, 42, 8, 0, -36, -40, 9, -20, -8, -3, -16, -20, -17, 12, -13, -28, -11, -28, -3},
        '{-29, 21, -10, 34, -2, -3, -52, -46, -6, -33, 1, -4, -2, -9, 10, -3, 25, 28, 34, -40, -6},
        '{1, 10, -13, -4, -14, -15, -31, -23, -8, -30, 10, -1, 5, 3, 24, -8, 20, 37, 25, -18, -1}
    };
    localparam int RI [3] = '{1374, 346, -231};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_model(input logic [83:0] x);
        int         acc;
        logic [12:0] a;
        logic [2:0]  d;
        int          s0;
        int          s1;
        int          s2;
        logic [1:0]  cls;
        for (int c = 0; c < 3; c++) begin
            acc = RI[c];
            for (int f = 0; f < 21; f++) begin
                acc += int'(x[4*f +: 4]) * RW[c][f];
            end
            a    = acc[12:0];
            d[c] = a[12];
        end
        s0 = (d[0] ? 0 : 1) + (d[1] ? 0 : 1);
        s1 = (d[0] ? 1 : 0) + (d[2] ? 0 : 1);
        s2 = (d[1] ? 1 : 0) + (d[2] ? 1 : 0);
        if (s0 >= s1 && s0 >= s2)  cls = 2'd0;
        else if (s1 >= s2)         cls = 2'd1;
        else                       cls = 2'd2;
        return {cls, 2'(s0), 2'(s1), 2'(s2)};
    endfunction

    // Offer a sample (held until taken) and queue its expected result.
    task automatic send(input logic [83:0] data, input logic [7:0] expv);
        int t = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = data;
        while (!bus_if.in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus_if.in_ready) begin
            check("accept_timeout", 32'(bus_if.in_ready), 32'd1);
            bus_if.in_valid = 1'b0;
        end else begin
            exp_q.push_back('{cls: expv[7:6], votes: expv[5:0], acc: cyc + 1});
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state();
        check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_class", 32'(bus_if.out_class), 32'd0);
        check("rst_out_votes", 32'(bus_if.out_votes), 32'd0);
        check("rst_busy",      32'(busy),             32'd0);
    endtask

    // Monitor: latency on rising out_valid, hold stability, pop on handshake.
    initial begin
        logic       prev_valid;
        logic       prev_ready;
        logic [1:0] prev_cls;
        logic [5:0] prev_votes;
        exp_t       e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_cls   = 2'd0;
        prev_votes = 6'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 32'(bus_if.out_valid), 32'd1);
                    check("hold_class", 32'(bus_if.out_class), 32'(prev_cls));
                    check("hold_votes", 32'(bus_if.out_votes), 32'(prev_votes));
                end
                if (bus_if.out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) check("unexpected_result", 32'(exp_q.size()), 32'd1);
                    else                   check("latency", 32'(cyc - exp_q[0].acc), 32'd64);
                end
                if (bus_if.out_valid && bus_if.out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_class", 32'(bus_if.out_class), 32'(e.cls));
                    check("out_votes", 32'(bus_if.out_votes), 32'(e.votes));
                end
                prev_valid = bus_if.out_valid;
                prev_ready = bus_if.out_ready;
                prev_cls   = bus_if.out_class;
                prev_votes = bus_if.out_votes;
            end
        end
    end

    initial begin
        logic [83:0] x;
        int          seen;
        int          t;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state();

        send(84'h0, 8'b00_100001);
        wait_drain();

        // Reset while idle.
        apply_reset();
        check_reset_state();

        send(84'hFFFFFFFFFFFFFFFFFFFFF, 8'b10_000110);
        send(84'h00FFF0FFF000000000000, 8'b01_011000);
        send(84'h00000000000000F000000, 8'b10_010010);
        send(84'h0000000FF0F000000000F, 8'b00_010101);
        wait_drain();

        // Backpressure: result held 10 cycles while a second sample waits.
        bus_if.out_ready = 1'b0;
        send(84'h0, 8'b00_100001);
        fork
            send(84'hFFFFFFFFFFFFFFFFFFFFF, 8'b10_000110);
            begin
                t = 0;
                while (!bus_if.out_valid && t < 200) begin
                    @(posedge clk); #1;
                    t++;
                end
                check("bp_result_seen", 32'(bus_if.out_valid), 32'd1);
                repeat (10) begin
                    @(posedge clk); #1;
                    check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
                    check("bp_busy",     32'(busy),            32'd1);
                end
                bus_if.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset 30 cycles into the MAC phase of an all-F sample.
        send(84'hFFFFFFFFFFFFFFFFFFFFF, 8'b10_000110);
        repeat (29) @(posedge clk);
        #1;
        apply_reset();
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        send(84'h0, 8'b00_100001);
        wait_drain();

        // Random samples against the reference classifier.
        repeat (40) begin
            x[31:0]  = $urandom;
            x[63:32] = $urandom;
            x[83:64] = 20'($urandom);
            send(x, ref_model(x));
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
